// File: rtl/tri_lcb_seq.sv
// Local clock-buffer sequencer for one tri_*_nlats latch region:
// init pulse on lclk[1], act/hold-not registers, and a drained clock-stop.
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 3
`endif

module tri_lcb_seq #(
  parameter int INIT_CYCLES    = 4,
  parameter int DRAIN_CYCLES   = 2,
  parameter int RESTART_CYCLES = 1
) (
  input  logic [0:`NCLK_WIDTH-1] nclk,
  inout  wire                    vd,
  inout  wire                    gd,
  input  logic                   act,
  input  logic                   thold,
  input  logic                   reinit_req,
  input  logic                   stop_req,
  output logic [0:`NCLK_WIDTH-1] lclk,
  output logic                   d1clk,
  output logic                   d2clk,
  output logic                   init_done,
  output logic                   stop_ack
);

  typedef enum logic [2:0] {
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_STOP,
    S_RESTART
  } state_t;

  localparam logic [7:0] L_INIT_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [7:0] L_DRN_LAST  = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] L_RST_LAST  = 8'(RESTART_CYCLES - 1);
  localparam bit         L_NO_DRAIN  = (DRAIN_CYCLES == 0);

  logic       w_clk;
  logic       w_rst;
  logic       w_unused;
  state_t     r_state;
  state_t     w_nstate;
  logic [7:0] r_cnt;
  logic [7:0] w_ncnt;
  logic       r_lclk1;
  logic       r_d1;
  logic       r_d2;
  logic       r_done;
  logic       r_ack;
  logic       w_lclk1;
  logic       w_d1;
  logic       w_d2;
  logic       w_done;
  logic       w_ack;

  assign w_clk    = nclk[0];
  assign w_rst    = nclk[1];
  assign w_unused = vd ^ gd;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    unique case (r_state)
      S_INIT: begin
        if (r_cnt == L_INIT_LAST) begin
          w_nstate = S_RUN;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + 8'd1;
        end
      end
      S_RUN: begin
        if (stop_req) begin
          w_nstate = L_NO_DRAIN ? S_STOP : S_DRAIN;
          w_ncnt   = '0;
        end
      end
      S_DRAIN: begin
        // a dropped request aborts the drain before it can complete
        if (!stop_req) begin
          w_nstate = S_RUN;
          w_ncnt   = '0;
        end else if (r_cnt == L_DRN_LAST) begin
          w_nstate = S_STOP;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + 8'd1;
        end
      end
      S_STOP: begin
        if (!stop_req) begin
          w_nstate = S_RESTART;
          w_ncnt   = '0;
        end
      end
      S_RESTART: begin
        if (r_cnt == L_RST_LAST) begin
          w_nstate = S_RUN;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_nstate = S_INIT;
        w_ncnt   = '0;
      end
    endcase
    if (reinit_req) begin
      w_nstate = S_INIT;
      w_ncnt   = '0;
    end
  end

  always_comb begin
    w_lclk1 = 1'b0;
    w_d1    = 1'b0;
    w_d2    = 1'b0;
    w_done  = 1'b1;
    w_ack   = 1'b0;
    unique case (w_nstate)
      S_INIT: begin
        w_lclk1 = 1'b1;
        w_d2    = 1'b1;
        w_done  = 1'b0;
      end
      S_RUN: begin
        w_d1 = act;
        w_d2 = ~thold;
      end
      S_DRAIN:   w_d2  = ~thold;
      S_STOP:    w_ack = 1'b1;
      S_RESTART: w_d2  = 1'b1;
      default:   w_done = 1'b0;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_lclk1 <= 1'b1;
      r_d1    <= 1'b0;
      r_d2    <= 1'b0;
      r_done  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_lclk1 <= w_lclk1;
      r_d1    <= w_d1;
      r_d2    <= w_d2;
      r_done  <= w_done;
      r_ack   <= w_ack;
    end
  end

  always_comb begin
    lclk    = nclk;
    lclk[1] = r_lclk1;
  end

  assign d1clk     = r_d1;
  assign d2clk     = r_d2;
  assign init_done = r_done;
  assign stop_ack  = r_ack;

endmodule

// File: doc/tri_lcb_seq.md
# tri_lcb_seq

Local clock-buffer sequencer that drives the control side of the `tri_*_nlats` latch banks: it generates the `lclk` bus, with `lclk[1]` as the stretched synchronous init pulse, plus `d1clk` (act) and `d2clk` (hold-not). It owns power-on and software re-init of a latch region, and a clock-stop handshake that drains in-flight updates before freezing the region. One instance sits per latch region, between the clock/reset distribution and the latch banks it feeds.

## Interface
Parameters:
- `INIT_CYCLES`, 4, cycles `lclk[1]` stays high after reset or re-init (1..255)
- `DRAIN_CYCLES`, 2, cycles with `d1clk` forced low before freeze (0..15)
- `RESTART_CYCLES`, 1, cycles with `d2clk` high and `d1clk` low before resuming (1..15)

Ports:
- `nclk`  in  [0:`NCLK_WIDTH-1]  `nclk[0]` is the single clock (posedge); `nclk[1]` is the reset, synchronous and active-high
- `vd`, `gd`  inout  1  power pins, unused in logic
- `act`  in  1  functional update enable
- `thold`  in  1  hold, active high
- `reinit_req`  in  1  single-cycle pulse that re-runs the init sequence
- `stop_req`  in  1  level; requests a clock stop
- `lclk`  out  [0:`NCLK_WIDTH-1]  bit 0 = `nclk[0]` passthrough; bit 1 = registered sreset; other bits = `nclk` passthrough
- `d1clk`  out  1  registered act to latches
- `d2clk`  out  1  registered hold-not to latches
- `init_done`  out  1  high in RUN, DRAIN, STOPPED, RESTART
- `stop_ack`  out  1  high only in STOPPED

## Operation
- States: INIT, RUN, DRAIN, STOPPED, RESTART. Counter `cnt` is 8 bits.
- All outputs except the passthrough bits are registered Moore outputs, computed from the next state at each edge.
- Priority: `nclk[1]` > `reinit_req` > stop handshake > normal.
- `nclk[1]`=1: state←INIT, cnt←0, `lclk[1]`←1, `d1clk`←0, `d2clk`←0, `init_done`←0, `stop_ack`←0. These are the reset values of all registered outputs.
- INIT:
  - `lclk[1]`=1, `d1clk`=0, `d2clk`=1; cnt increments each cycle.
  - When cnt==INIT_CYCLES-1 → RUN, with cnt←0.
- RUN:
  - `lclk[1]`=0, `d1clk`←`act`, `d2clk`←~`thold`, `init_done`=1.
  - `stop_req`=1 → DRAIN, or → STOPPED directly if DRAIN_CYCLES==0.
- DRAIN:
  - `d1clk`=0, `d2clk`←~`thold`; cnt counts to DRAIN_CYCLES-1, then → STOPPED.
  - `stop_req` dropping mid-drain → RUN on the next edge, with cnt←0.
- STOPPED:
  - `d1clk`=0, `d2clk`=0, `stop_ack`=1.
  - `stop_req`=0 → RESTART.
- RESTART:
  - `d1clk`=0, `d2clk`=1, `stop_ack`=0; counts RESTART_CYCLES, then → RUN.
  - `stop_req` reasserting during RESTART is ignored until RUN is reached.
- `reinit_req` in any state other than INIT → INIT with cnt←0. `stop_ack` and `init_done` drop on the same edge.
- `reinit_req` during INIT restarts the count (cnt←0).
- `thold` is honoured in RUN and DRAIN only; INIT and RESTART force `d2clk`=1.

## Timing
- `act` → `d1clk`: 1 cycle. `thold` → `d2clk`: 1 cycle.
- Deassertion of `nclk[1]` at edge E: `lclk[1]` is high for edges E..E+INIT_CYCLES-1; `init_done` rises at E+INIT_CYCLES.
- `stop_req` sampled high at edge S in RUN: `d1clk`=0 from S; `stop_ack`=1 from S+DRAIN_CYCLES (S+0 when DRAIN_CYCLES==0 counts as the same edge going straight to STOPPED).
- `stop_req` sampled low at edge R in STOPPED: `stop_ack`=0 from R; `d1clk` follows `act` again from R+RESTART_CYCLES.
- `reinit_req` and `stop_req` arriving on the same edge: INIT wins, and `stop_req` is re-evaluated after INIT completes.

## Test plan
- Reset with INIT_CYCLES=4: hold `nclk[1]` for 3 cycles, then release at edge E -> `lclk[1]`=1 through E+3, `init_done`=1 at E+4, `d1clk`/`d2clk` = 0/1 during INIT.
- RUN toggling with `act`=1,0,1 and `thold`=0,1,0 -> `d1clk`=1,0,1 and `d2clk`=1,0,1, each delayed by exactly 1 cycle.
- Stop/restart with DRAIN_CYCLES=2, RESTART_CYCLES=1: `stop_req`↑ at S -> `d1clk`=0 from S, `stop_ack`=1 at S+2 with `d2clk`=0; `stop_req`↓ at R -> `stop_ack`=0 and `d2clk`=1 at R, `d1clk`=`act` at R+1.
- Abort: `stop_req` pulses high for 1 cycle during DRAIN -> returns to RUN, `stop_ack` never asserts.
- `reinit_req` in STOPPED -> `stop_ack`↓ and `lclk[1]`↑ on the same edge, 4-cycle init, then RUN while `stop_req` is still high -> DRAIN entered on the first RUN edge.
- DRAIN_CYCLES=0 build: `stop_req`↑ at S -> `stop_ack`=1 and `d2clk`=0 at S; `nclk[1]` asserted mid-STOPPED -> all registered outputs take their reset values on the next edge.
